// File: rtl/lpc_record_buffer.sv
// lpc_record_buffer: captures completed LPC transactions from the decoder into a
// record FIFO and serializes each record as a 6-byte frame on a valid/ready byte
// stream. Records lost to a full FIFO are counted and flagged on the next frame.
module lpc_record_buffer #(
  parameter int unsigned DEPTH = 16
) (
  input  logic        lpc_clock,
  input  logic        lpc_reset,
  input  logic [3:0]  in_cyctype_dir,
  input  logic [31:0] in_addr,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic [7:0]  out_byte,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        fifo_empty,
  output logic        fifo_full,
  output logic [7:0]  overflow_count
);

  localparam int unsigned IdxW  = $clog2(DEPTH);
  localparam int unsigned PtrW  = IdxW + 1;
  // Record layout: {lost, cyctype_dir[3:0], addr[31:0], data[7:0]}
  localparam int unsigned RecW  = 1 + 4 + 32 + 8;
  localparam int unsigned FrmW  = 48;

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e              state_q, state_d;
  logic                prev_valid_q;
  logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic                lost_pending_q;
  logic [7:0]          overflow_count_q;
  logic [FrmW-1:0]     frame_q, frame_d;
  logic [2:0]          idx_q, idx_d;
  logic [RecW-1:0]     mem [DEPTH];
  logic [RecW-1:0]     head;
  logic                capture, push, drop, pop;

  // Only a 0->1 transition of the decoder strobe is a new transaction.
  assign capture = in_valid & ~prev_valid_q;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[IdxW-1:0] == rd_ptr_q[IdxW-1:0]) &&
                      (wr_ptr_q[IdxW] != rd_ptr_q[IdxW]);

  // Fullness is judged on pre-edge occupancy; a same-edge pop does not save a capture.
  assign push = capture & ~fifo_full;
  assign drop = capture & fifo_full;

  assign head           = mem[rd_ptr_q[IdxW-1:0]];
  assign out_byte       = frame_q[FrmW-1 -: 8];
  assign overflow_count = overflow_count_q;

  // Edge-detect history; resets high so a level already asserted at release is ignored.
  always_ff @(posedge lpc_clock or negedge lpc_reset) begin
    if (!lpc_reset) begin
      prev_valid_q <= 1'b1;
    end else begin
      prev_valid_q <= in_valid;
    end
  end

  // Record storage; contents need no reset since the pointers gate visibility.
  always_ff @(posedge lpc_clock) begin
    if (push) begin
      mem[wr_ptr_q[IdxW-1:0]] <= {lost_pending_q, in_cyctype_dir, in_addr, in_data};
    end
  end

  // FIFO pointers.
  always_ff @(posedge lpc_clock or negedge lpc_reset) begin
    if (!lpc_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Overflow bookkeeping: lost flag rides on the next stored record, count saturates.
  always_ff @(posedge lpc_clock or negedge lpc_reset) begin
    if (!lpc_reset) begin
      lost_pending_q   <= 1'b0;
      overflow_count_q <= 8'h00;
    end else begin
      if (drop) begin
        lost_pending_q <= 1'b1;
        if (overflow_count_q != 8'hFF) overflow_count_q <= overflow_count_q + 8'd1;
      end else if (push) begin
        lost_pending_q <= 1'b0;
      end
    end
  end

  // Serializer state, shift register and byte index.
  always_ff @(posedge lpc_clock or negedge lpc_reset) begin
    if (!lpc_reset) begin
      state_q <= StIdle;
      frame_q <= '0;
      idx_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      idx_q   <= idx_d;
    end
  end

  // Serializer next state: load a frame in idle, shift one byte per acceptance in send.
  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    idx_d     = idx_q;
    pop       = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          frame_d = {head[43:40], 3'b000, head[44], head[39:0]};
          idx_d   = 3'd0;
          state_d = StSend;
        end
      end
      StSend: begin
        out_valid = 1'b1;
        if (out_ready) begin
          frame_d = {frame_q[FrmW-9:0], 8'h00};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd5) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

endmodule
